mini_alu_sequencer: RTL
=======================

Name: mini_alu_sequencer

Overview:
- Clocked controller that runs a short stored program of ALU operations through the combinational mini_processor datapath.
- The datapath is A/B 4-bit, ctrl 2-bit, and has a result output.
- The block holds up to DEPTH instructions, issues them one at a time, and chains results through a 4-bit accumulator.
- It drives the ALU inputs, captures the result, and mirrors the accumulator onto the board LEDs.
- Sits between the board-level switch/button logic (program load, start) and mini_processor.

Parameters:
- DEPTH, 8: number of program slots. Power of two.
- AW, 3: program address width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- prog_we  input  1  program write strobe
- prog_addr  input  AW  program write address
- prog_data  input  11  instruction word: [10:9] op, [8] src_acc, [7:4] a_imm, [3:0] b_imm
- prog_len  input  AW+1  number of instructions to run (0..DEPTH), sampled on start
- start  input  1  run request, single-cycle pulse or level
- busy  output  1  high while the program executes
- done  output  1  one-cycle pulse at end of run
- alu_a  output  4  to mini_processor A
- alu_b  output  4  to mini_processor B
- alu_ctrl  output  2  to mini_processor ctrl (00 ADD, 01 SUB, 10 AND, 11 OR)
- alu_result  input  4  from mini_processor result (combinational)
- acc  output  4  accumulator value
- led  output  4  LED drive, equals acc

Behaviour:
- Reset (async, any state, including mid-run):
  - state IDLE; pc 0; len_q 0.
  - acc, led, alu_a, alu_b, alu_ctrl all 0; busy 0; done 0.
  - Program memory cleared to all zeros (ADD 0+0).
- All outputs are registered.
- States:
  - IDLE
  - ISSUE
  - CAPTURE
  - DONE
- IDLE:
  - start=1 and prog_len>0: latch len_q=min(prog_len,DEPTH), pc=0, go to ISSUE. busy rises the next cycle.
  - start=1 and prog_len=0: go straight to DONE. acc unchanged, no ALU activity.
- ISSUE (busy=1), instruction i=mem[pc]:
  - At the cycle end, load alu_ctrl=i.op and alu_b=i.b_imm.
  - Load alu_a=acc if i.src_acc=1, else i.a_imm.
  - Go to CAPTURE.
- CAPTURE (busy=1):
  - alu_result is settled from the registered ALU inputs.
  - At the cycle end, acc<=alu_result and led<=alu_result.
  - If pc==len_q-1, go to DONE; else pc<=pc+1 and go to ISSUE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE.
  - alu_* keep their last values. acc holds until the next run or reset.
- Latency: for N≥1, the first busy cycle is the cycle after start is sampled, and done asserts 2N+1 cycles after start is sampled.
- Arithmetic: 4-bit modulo in the ALU; no carry/borrow is captured. The sequencer never widens or saturates.
- Program writes:
  - Accepted only in IDLE or DONE.
  - prog_we while busy is ignored; memory is unchanged.
  - A write and a start in the same IDLE cycle: the write lands first, so the run sees the new word.
- start while busy or in DONE: ignored, no queuing.
- prog_len>DEPTH is clamped to DEPTH.
- pc never wraps during a run.
- acc is not cleared at start. Programs that need a clean accumulator use src_acc=0 on their first instruction.

Decomposition:
- Package mini_proc_pkg holds:
  - op constants OP_ADD/SUB/AND/OR.
  - the FSM state encoding (2 bits).
  - instruction field positions/widths (OP_HI/LO, SRC_ACC_BIT, A_HI/LO, B_HI/LO).
  - INSTR_W=11.
- One sub-module: mini_prog_mem, a DEPTH×11 register file with async-reset clear, synchronous write, combinational read at pc.
- The FSM, accumulator and ALU drive registers stay in mini_alu_sequencer.
- mini_processor is instantiated beside the sequencer at the top level, not inside it.

Test Plan:
- Single ADD: load slot0 {00,0,0101,0011}, prog_len=1, start.
  - Required: alu_a=0101, alu_b=0011, alu_ctrl=00; acc=led=1000.
  - done pulses exactly 3 cycles after start is sampled; busy high for 2 cycles.
- Chained program of 4 instructions:
  - {00,0,0101,0011} gives acc 1000.
  - {01,1,-,0001} gives 0111.
  - {10,1,-,1100} gives 0100.
  - {11,1,-,1010} gives 1110.
  - Required: final acc=led=1110; done at cycle 9.
- Wrap-around: {00,0,1111,0001} gives acc 0000; then {01,1,-,0001} gives acc 1111.
- prog_len=0 start: done pulses the next cycle; busy never asserts; acc unchanged.
- Ignored inputs: start and prog_we pulsed mid-run.
  - Required: run length unchanged; memory word unchanged; no second done.
- Reset mid-run: assert rst during CAPTURE of instruction 2.
  - Required: busy, done, acc, led and alu_* are all 0 immediately, without waiting for a clock edge.
  - Required: memory is zero; a restarted prog_len=1 run yields acc 0000.

Source files
------------

// File: rtl/mini_proc_pkg.sv
// Shared constants for the mini ALU sequencer: ALU opcodes, FSM encoding and
// the layout of the 11-bit instruction word.
package mini_proc_pkg;

    localparam int INSTR_W = 11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int OP_HI       = 10;
    localparam int OP_LO       = 9;
    localparam int SRC_ACC_BIT = 8;
    localparam int A_HI        = 7;
    localparam int A_LO        = 4;
    localparam int B_HI        = 3;
    localparam int B_LO        = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mini_prog_mem.sv
// Program store: DEPTH x INSTR_W register file, cleared on reset, written
// synchronously and read combinationally at the current pc.
module mini_prog_mem
    import mini_proc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [DEPTH-1:0][INSTR_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mini_alu_sequencer.sv
// Runs a stored program through an external combinational ALU, one
// instruction per ISSUE/CAPTURE pair, chaining results through acc.
module mini_alu_sequencer
    import mini_proc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [1:0]         alu_ctrl,
    input  logic [3:0]         alu_result,
    output logic [3:0]         acc,
    output logic [3:0]         led
);

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW:0]        len_q, len_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         a_q, a_d;
    logic [3:0]         b_q, b_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mem_we;
    logic               last_instr;
    logic [INSTR_W-1:0] instr;

    mini_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    // Writes only land while no program is executing.
    assign mem_we     = prog_we && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_instr = ({1'b0, pc_q} + (AW+1)'(1)) == len_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
                        pc_d    = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                ctrl_d  = instr[OP_HI:OP_LO];
                b_d     = instr[B_HI:B_LO];
                a_d     = instr[SRC_ACC_BIT] ? acc_q : instr[A_HI:A_LO];
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                acc_d = alu_result;
                if (last_instr) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = ctrl_q;
    assign acc      = acc_q;
    assign led      = acc_q;

endmodule
